// File: rtl/dsp_pkg.sv
// Shared DSP48A1 slice definitions: operand widths, OPMODE fields, mux encodings.
package dsp_pkg;

    localparam int unsigned P_W   = 48;
    localparam int unsigned M_W   = 36;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned SUM_W = P_W + 1;

    localparam int unsigned OP_CIN_BIT = 5;
    localparam int unsigned OP_SUB_BIT = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    // Post-adder result: carry/borrow above the 48-bit sum.
    typedef struct packed {
        logic           co;
        logic [P_W-1:0] sum;
    } post_add_t;

endpackage

// File: rtl/opt_pipe_reg.sv
// Optional pipeline register: always-clocked storage with clock enable and a
// parameter-selected register/bypass output mux.
module opt_pipe_reg #(
    parameter int unsigned WIDTH  = 1,
    parameter bit          EN_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (ce) begin
            q_reg <= d;
        end
    end

    assign q = EN_REG ? q_reg : d;

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/accumulator of the DSP48A1 slice: X/Z operand muxes, add/subtract
// with carry-in, optional OPMODE, carry-in, P and carry-out pipeline registers.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter string RSTTYPE     = "ASYNC",
    parameter bit    OPMODEREG   = 1'b1,
    parameter bit    CARRYINREG  = 1'b1,
    parameter bit    PREG        = 1'b1,
    parameter bit    CARRYOUTREG = 1'b1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CEOPMODE,
    input  logic            CECARRYIN,
    input  logic            CEP,
    input  logic [OP_W-1:0] OPMODE,
    input  logic [M_W-1:0]  M,
    input  logic [P_W-1:0]  DAB,
    input  logic [P_W-1:0]  C,
    input  logic [P_W-1:0]  PCIN,
    input  logic            CARRYIN,
    output logic [P_W-1:0]  P,
    output logic [P_W-1:0]  PCOUT,
    output logic            CARRYOUT,
    output logic            CARRYOUTF
);

    localparam bit CIN_FROM_OP   = (CARRYINSEL == "OPMODE5");
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

    generate
        if (RSTTYPE != "ASYNC") begin : g_bad_rsttype
            $error("dsp_post_adder: RSTTYPE must be ASYNC");
        end
    endgenerate

    logic [OP_W-1:0] opmode_q;
    logic            cin_src;
    logic            cin;
    logic [P_W-1:0]  p_reg;
    logic            co_reg;
    logic [P_W-1:0]  x_op;
    logic [P_W-1:0]  z_op;
    post_add_t       res;
    logic            unused_opmode;

    // OPMODE[4] and OPMODE[6] belong to the pre-adder stage.
    assign unused_opmode = ^{opmode_q[6], opmode_q[4]};

    opt_pipe_reg #(.WIDTH(OP_W), .EN_REG(OPMODEREG)) u_opmode_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEOPMODE),
        .d   (OPMODE),
        .q   (opmode_q)
    );

    // Carry source is chosen from the raw OPMODE so it lines up with the OPMODE register.
    assign cin_src = CIN_FROM_OP   ? OPMODE[OP_CIN_BIT] :
                     CIN_FROM_PORT ? CARRYIN : 1'b0;

    opt_pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG)) u_cin_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CECARRYIN),
        .d   (cin_src),
        .q   (cin)
    );

    // Operand muxes and add/subtract; P feedback always taps the internal register.
    always_comb begin
        x_op = '0;
        z_op = '0;
        unique case (x_sel_e'(opmode_q[1:0]))
            X_ZERO: x_op = '0;
            X_M:    x_op = {{(P_W-M_W){1'b0}}, M};
            X_P:    x_op = p_reg;
            X_DAB:  x_op = DAB;
        endcase
        unique case (z_sel_e'(opmode_q[3:2]))
            Z_ZERO: z_op = '0;
            Z_PCIN: z_op = PCIN;
            Z_P:    z_op = p_reg;
            Z_C:    z_op = C;
        endcase
        if (opmode_q[OP_SUB_BIT]) begin
            res = post_add_t'({1'b0, z_op} - ({1'b0, x_op} + SUM_W'(cin)));
        end else begin
            res = post_add_t'({1'b0, z_op} + {1'b0, x_op} + SUM_W'(cin));
        end
    end

    opt_pipe_reg #(.WIDTH(P_W), .EN_REG(1'b1)) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEP),
        .d   (res.sum),
        .q   (p_reg)
    );

    opt_pipe_reg #(.WIDTH(1), .EN_REG(1'b1)) u_co_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEP),
        .d   (res.co),
        .q   (co_reg)
    );

    assign P         = PREG        ? p_reg  : res.sum;
    assign PCOUT     = P;
    assign CARRYOUT  = CARRYOUTREG ? co_reg : res.co;
    assign CARRYOUTF = CARRYOUT;

endmodule

// File: doc/dsp_post_adder.md
# dsp_post_adder

Post-adder/accumulator stage of the DSP48A1 slice model. Sits directly downstream of the M (multiplier) pipeline register: selects X and Z operands from the product, the D:A:B concatenation, C, PCIN or its own P feedback, adds or subtracts them with a carry-in, and drives the P and CARRYOUT outputs through optional pipeline registers. Upstream operands arrive already registered or bypassed by their own pipeline stages; this block owns only the OPMODE, carry-in, P and carry-out registers.

## Interface
- RSTTYPE, "ASYNC": fixed for this block; present only for parameter-list compatibility with the rest of the slice; any other value is a elaboration error.
- OPMODEREG, 1: 1 = OPMODE passes through a register; 0 = used directly.
- CARRYINREG, 1: 1 = selected carry-in registered; 0 = bypass.
- PREG, 1: 1 = P output from register; 0 = combinational sum.
- CARRYOUTREG, 1: 1 = CARRYOUT from register; 0 = combinational.
- CARRYINSEL, "OPMODE5": "OPMODE5" = carry-in source is OPMODE[5]; "CARRYIN" = CARRYIN port; other values drive carry-in 0.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; clears every internal register.
- CEOPMODE  input  1  clock enable, OPMODE register.
- CECARRYIN  input  1  clock enable, carry-in register.
- CEP  input  1  clock enable, P and carry-out registers.
- OPMODE  input  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] subtract; [4],[6] ignored here.
- M  input  36  product from M stage.
- DAB  input  48  {D[11:0], A[17:0], B[17:0]}.
- C  input  48  C operand.
- PCIN  input  48  cascade input.
- CARRYIN  input  1  external carry-in.
- P  output  48  result.
- PCOUT  output  48  copy of P.
- CARRYOUT  output  1  post-adder carry/borrow.
- CARRYOUTF  output  1  copy of CARRYOUT.

## Operation
- X mux (OPMODE[1:0]): 0 -> 0; 1 -> {12'b0, M}; 2 -> P feedback; 3 -> DAB.
- Z mux (OPMODE[3:2]): 0 -> 0; 1 -> PCIN; 2 -> P feedback; 3 -> C.
- P feedback is always the internal P register, regardless of PREG.
- CIN = selected carry source, through carry-in register if CARRYINREG.
- OPMODE[7]=0: {co, sum} = Z + X + CIN in 49 bits.
- OPMODE[7]=1: {co, sum} = Z - (X + CIN) in 49 bits; co is bit 48 of the two's-complement result (1 = borrow).
- Wrap-around: sum truncated to 48 bits, no saturation.
- Internal P/carry-out registers load {co, sum} when CEP=1, hold when CEP=0; always clocked even when PREG/CARRYOUTREG=0.
- PREG=0: P = sum combinationally; CARRYOUTREG=0: CARRYOUT = co.
- Reset (rst=0): OPMODE, carry-in, P and carry-out registers -> 0 immediately, independent of clk and CE; P, PCOUT, CARRYOUT, CARRYOUTF read 0 when registered. Reset mid-accumulation discards the running sum; first edge after release with CEP=1 restarts from P=0.
- Reset dominates CE; CE dominates data.

## Timing
- All registers enabled: OPMODE/CIN changes at edge n are used for the sum after edge n and appear on P after edge n+1 (2 cycles). Data inputs (M, C, DAB, PCIN) applied before edge n appear on P after edge n (1 cycle).
- OPMODEREG=0 and CARRYINREG=0: every input reaches P after 1 edge with PREG=1; 0 edges with PREG=0.
- Accumulation (X=M, Z=P): P[n+1] = P[n] + M[n] + CIN each cycle with CEP=1.

## Structure
- Shared package dsp_pkg: X/Z select encodings (X_ZERO, X_M, X_P, X_DAB; Z_ZERO, Z_PCIN, Z_P, Z_C), OPMODE bit indices, width constants (48, 36).
- Sub-module opt_pipe_reg (WIDTH, EN_REG): async active-low reset, CE, register/bypass mux; instantiated for OPMODE, carry-in, P and carry-out.

## Test plan
- Reset: drive P to 48'h1234, assert rst low between edges -> P, PCOUT, CARRYOUT read 0 before the next edge.
- Add: OPMODE=8'h0D (X=M, Z=C), M=36'd100, C=48'd5, CIN=0 -> P=105, CARRYOUT=0, 2 edges after OPMODE change.
- Overflow: X=DAB=48'hFFFF_FFFF_FFFF, Z=0, OPMODE[5]=1 -> P=0, CARRYOUT=1.
- Subtract: OPMODE=8'h8D, C=10, M=3, CIN=0 -> P=7, CARRYOUT=0; M=11 -> P=48'hFFFF_FFFF_FFFF, CARRYOUT=1.
- Accumulate with CE: X=M, Z=P, M=2 for 5 edges -> P=2,4,6,8,10; CEP=0 for 2 edges -> P holds 10.
- Bypass: all *REG=0, OPMODE=8'h0D, C=7, M=1 -> P=8 in the same cycle, no clock edge needed.
